// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer: channel count, select width and
// select decode helper.
package demux_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef logic [SEL_W-1:0] ch_idx_t;

  function automatic logic [NUM_CH-1:0] sel_onehot(ch_idx_t idx);
    logic [NUM_CH-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One output channel: a single-entry valid/ready register plus a wrapping count of words
// delivered to the consumer.
module demux_out_slot #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  count_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              drain;

  // The parent only asserts load_i when the slot is empty or draining, so a held word is
  // never overwritten before it is delivered.
  always_comb begin
    drain   = valid_q & ready_i;
    valid_d = load_i | (valid_q & ~ready_i);
    data_d  = load_i ? data_i : data_q;
    count_d = drain ? count_q + CNT_W'(1) : count_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign count_o = count_q;

endmodule

// File: rtl/demux_1to4_stream.sv
// Registered 1-to-4 stream demultiplexer: steers each accepted input word into the output slot
// chosen by {sb,sa}; only the selected slot can stall the producer.
module demux_1to4_stream
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     sa,
  input  logic                     sb,
  output logic [NUM_CH-1:0]        m_valid,
  input  logic [NUM_CH-1:0]        m_ready,
  output logic [NUM_CH*DATA_W-1:0] m_data,
  output logic [NUM_CH*CNT_W-1:0]  m_count
);

  ch_idx_t           sel;
  logic [NUM_CH-1:0] sel_oh;
  logic              accept;
  logic [NUM_CH-1:0] load;

  always_comb begin
    sel     = {sb, sa};
    sel_oh  = sel_onehot(sel);
    s_ready = ~rst & (~m_valid[sel] | m_ready[sel]);
    accept  = s_valid & s_ready;
    load    = sel_oh & {NUM_CH{accept}};
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_out_slot #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_slot (
      .clk_i   (clk),
      .rst_i   (rst),
      .load_i  (load[k]),
      .data_i  (s_data),
      .ready_i (m_ready[k]),
      .valid_o (m_valid[k]),
      .data_o  (m_data[k*DATA_W +: DATA_W]),
      .count_o (m_count[k*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Self-checking bench for demux_1to4_stream: a per-channel scoreboard fed on accept and
// drained on delivery, plus directed checks for routing, backpressure, reset and wrap.
module tb_demux_1to4_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        sa;
  logic        sb;
  logic [3:0]  m_valid;
  logic [3:0]  m_ready;
  logic [31:0] m_data;
  logic [31:0] m_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0] exp_q[4][$];
  logic [3:0] exp_valid;
  logic [7:0] exp_data[4];
  logic [7:0] exp_cnt[4];

  demux_1to4_stream #(
    .DATA_W (8),
    .CNT_W  (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .sa      (sa),
    .sb      (sb),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_count (m_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model runs on the falling edge: compare, then advance to what the next rising edge does.
  initial begin
    logic [1:0] sel;
    logic       exp_sready;
    logic [7:0] word;
    exp_valid = '0;
    for (int k = 0; k < 4; k++) begin
      exp_data[k] = '0;
      exp_cnt[k]  = '0;
    end
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int k = 0; k < 4; k++) begin
          exp_q[k].delete();
          exp_data[k] = '0;
          exp_cnt[k]  = '0;
        end
        exp_valid = '0;
      end
      sel        = {sb, sa};
      exp_sready = !rst && (!exp_valid[sel] || m_ready[sel]);
      check_eq("s_ready", {31'd0, s_ready}, {31'd0, exp_sready});
      check_eq("m_valid", {28'd0, m_valid}, {28'd0, exp_valid});
      for (int k = 0; k < 4; k++) begin
        check_eq("m_data", {24'd0, m_data[k*8 +: 8]}, {24'd0, exp_data[k]});
        check_eq("m_count", {24'd0, m_count[k*8 +: 8]}, {24'd0, exp_cnt[k]});
      end
      if (!rst) begin
        for (int k = 0; k < 4; k++) begin
          if (exp_valid[k] && m_ready[k]) begin
            word = 8'hxx;
            if (exp_q[k].size() > 0) word = exp_q[k].pop_front();
            check_eq("drain_word", {24'd0, m_data[k*8 +: 8]}, {24'd0, word});
            exp_cnt[k]   = exp_cnt[k] + 8'd1;
            exp_valid[k] = 1'b0;
          end
        end
        if (s_valid && exp_sready) begin
          exp_q[sel].push_back(s_data);
          exp_valid[sel] = 1'b1;
          exp_data[sel]  = s_data;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; sa = 1'b0; sb = 1'b0; m_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_sready", {31'd0, s_ready}, 32'd0);
    check_eq("rst_valid", {28'd0, m_valid}, 32'd0);
    check_eq("rst_count", m_count, 32'd0);
    rst = 1'b0;

    // Routing: one word per channel on consecutive clocks
    m_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      {sb, sa} = i[1:0];
      s_data = 8'((i + 1) * 17);
      step();
      check_eq("route_valid", {31'd0, m_valid[i]}, 32'd1);
      check_eq("route_data", {24'd0, m_data[i*8 +: 8]}, 32'((i + 1) * 17));
    end
    s_valid = 1'b0;
    step();
    check_eq("route_count", m_count, 32'h0101_0101);

    // Backpressure on ch1
    m_ready = 4'b1101;
    s_valid = 1'b1; {sb, sa} = 2'd1; s_data = 8'h55;
    step();
    s_data = 8'h66;
    #1 check_eq("bp_sready", {31'd0, s_ready}, 32'd0);
    step();
    check_eq("bp_hold", {24'd0, m_data[15:8]}, 32'h55);
    check_eq("bp_valid", {31'd0, m_valid[1]}, 32'd1);
    m_ready[1] = 1'b1;
    #1 check_eq("bp_release", {31'd0, s_ready}, 32'd1);
    step();
    check_eq("bp_load", {24'd0, m_data[15:8]}, 32'h66);
    check_eq("bp_valid2", {31'd0, m_valid[1]}, 32'd1);

    // Isolation: ch1 stalled full, ch3 still accepts
    s_valid = 1'b0; m_ready[1] = 1'b0;
    step();
    s_valid = 1'b1; {sb, sa} = 2'd3; s_data = 8'h77;
    #1 check_eq("iso_sready", {31'd0, s_ready}, 32'd1);
    step();
    s_valid = 1'b0;
    check_eq("iso_valid", {31'd0, m_valid[3]}, 32'd1);
    check_eq("iso_data", {24'd0, m_data[31:24]}, 32'h77);
    check_eq("iso_ch1", {24'd0, m_data[15:8]}, 32'h66);

    // Mid-stream reset with ch2 holding 0xA5
    m_ready = 4'b1011;
    s_valid = 1'b1; {sb, sa} = 2'd2; s_data = 8'hA5;
    step();
    check_eq("pre_rst_data", {24'd0, m_data[23:16]}, 32'hA5);
    #2 rst = 1'b1;
    #1;
    check_eq("mrst_valid", {28'd0, m_valid}, 32'd0);
    check_eq("mrst_count", m_count, 32'd0);
    check_eq("mrst_sready", {31'd0, s_ready}, 32'd0);
    check_eq("mrst_data", m_data, 32'd0);
    s_valid = 1'b0;
    step();
    rst = 1'b0;

    // Full rate into ch0
    m_ready = 4'hF; {sb, sa} = 2'd0;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_data = 8'(i);
      #1 check_eq("fr_sready", {31'd0, s_ready}, 32'd1);
      step();
      check_eq("fr_data", {24'd0, m_data[7:0]}, 32'(i));
      check_eq("fr_valid", {31'd0, m_valid[0]}, 32'd1);
    end
    s_valid = 1'b0;
    step();
    check_eq("fr_count", {24'd0, m_count[7:0]}, 32'd10);
    check_eq("fr_empty", {31'd0, m_valid[0]}, 32'd0);

    // Counter wrap on ch3
    {sb, sa} = 2'd3;
    for (int i = 0; i < 256; i++) begin
      s_valid = 1'b1;
      s_data = 8'(i);
      step();
      if (i == 255) check_eq("wrap_pre", {24'd0, m_count[31:24]}, 32'd255);
    end
    s_valid = 1'b0;
    step();
    check_eq("wrap_count", m_count, 32'h0000_000A);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
